// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode values, controller state encoding and instruction classes
// for the hardwired CPU control sequencer.
package cpu_ctrl_pkg;

    localparam int OPC_BITS = 5;

    localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_BITS-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_BITS-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_BITS-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_BITS-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_BITS-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPC_BITS-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPC_BITS-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_BITS-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_BITS-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_BITS-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_BITS-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_BITS-1:0] OP_JR   = 5'b10100;
    localparam logic [OPC_BITS-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_BITS-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST, F0, F1, F2, T3, T4, T5, T6, IDLE, HALT
    } state_t;

    // Class names carry a prefix so CL_HALT does not collide with the HALT state.
    typedef enum logic [2:0] {
        CL_RTYPE, CL_ITYPE, CL_BR, CL_JR, CL_NOP, CL_HALT, CL_BAD
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode decode: instruction class plus the ALU operation
// used in the execute states.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_BITS-1:0] opcode,
    output instr_class_t        cls,
    output logic [OPC_BITS-1:0] alu_op
);

    always_comb begin
        cls    = CL_BAD;
        alu_op = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                cls    = CL_RTYPE;
                alu_op = opcode;
            end
            OP_ADDI: begin cls = CL_ITYPE; alu_op = OP_ADD; end
            OP_ANDI: begin cls = CL_ITYPE; alu_op = OP_AND; end
            OP_ORI:  begin cls = CL_ITYPE; alu_op = OP_OR;  end
            // Branch target is PC + C, computed with an add in T5.
            OP_BR:   begin cls = CL_BR;    alu_op = OP_ADD; end
            OP_JR:   cls = CL_JR;
            OP_NOP:  cls = CL_NOP;
            OP_HALT: cls = CL_HALT;
            default: cls = CL_BAD;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: walks fetch and execute states and drives
// every datapath strobe of the 32-bit CPU from the current state.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W  = 32,
    parameter int OPC_W = OPC_BITS
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Stop,
    input  logic [IR_W-1:0]  IR,
    input  logic             CON_out,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             Cout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic             GRA,
    output logic             GRB,
    output logic             GRC,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             CON_in,
    output logic [OPC_W-1:0] operation,
    output logic             Run,
    output logic             Illegal
);

    state_t             state_q, state_d, end_state;
    instr_class_t       dec_cls, cls_q;
    logic [OPC_W-1:0]   dec_op, op_q;
    logic [OPC_W-1:0]   opcode;
    logic               unused_ir;

    assign opcode    = IR[IR_W-1 -: OPC_W];
    assign unused_ir = ^IR[IR_W-OPC_W-1:0];
    assign end_state = Stop ? IDLE : F0;

    instr_class_decode u_decode (
        .opcode (opcode),
        .cls    (dec_cls),
        .alu_op (dec_op)
    );

    // Class and ALU op are captured leaving T3 so T4..T6 depend on state only.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= RST;
            cls_q   <= CL_NOP;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T3) begin
                cls_q <= dec_cls;
                op_q  <= dec_op;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:  state_d = F0;
            F0:   state_d = F1;
            F1:   state_d = F2;
            F2:   state_d = T3;
            T3: begin
                case (dec_cls)
                    CL_JR, CL_NOP, CL_BAD: state_d = end_state;
                    CL_HALT:               state_d = HALT;
                    default:               state_d = T4;
                endcase
            end
            T4:   state_d = T5;
            T5:   state_d = (cls_q == CL_BR && CON_out) ? T6 : end_state;
            T6:   state_d = end_state;
            IDLE: state_d = Stop ? IDLE : F0;
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout  = 1'b0;
        MARin = 1'b0; Zin     = 1'b0; PCin   = 1'b0; MDRin = 1'b0;
        IRin  = 1'b0; Yin     = 1'b0; IncPC  = 1'b0; Read  = 1'b0;
        Write = 1'b0; GRA     = 1'b0; GRB    = 1'b0; GRC   = 1'b0;
        Rin   = 1'b0; Rout    = 1'b0; BAout  = 1'b0; CON_in = 1'b0;
        operation = '0;
        Run       = 1'b0;
        Illegal   = 1'b0;
        case (state_q)
            F0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            F1: begin Run = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            F2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                Run = 1'b1;
                case (dec_cls)
                    CL_RTYPE, CL_ITYPE: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_BR:   begin GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
                    CL_JR:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    CL_BAD:  Illegal = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                Run = 1'b1;
                case (cls_q)
                    CL_RTYPE: begin GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = op_q; end
                    CL_ITYPE: begin Cout = 1'b1; Zin = 1'b1; operation = op_q; end
                    CL_BR:    begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                Run = 1'b1;
                case (cls_q)
                    CL_RTYPE, CL_ITYPE: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                    CL_BR:   begin Cout = 1'b1; Zin = 1'b1; operation = op_q; end
                    default: ;
                endcase
            end
            T6: begin Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: stimulus pushes the
// expected per-cycle strobe set, a negedge monitor pops and compares.
module tb_control_sequencer;

  typedef struct packed {
    logic PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, CON_in;
    logic [4:0] operation;
    logic Run, Illegal;
  } obs_t;

  typedef struct {
    obs_t v;
    int   tag;
    int   idx;
  } exp_t;

  localparam obs_t ZERO = '0;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stop = 1'b0;
  logic [31:0] IR = '0;
  logic        CON_out = 1'b0;
  logic PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, CON_in;
  logic [4:0] operation;
  logic Run, Illegal;

  exp_t q[$];
  obs_t seq[$];
  int   total = 0;
  int   bad = 0;
  int   cur_tag = 0;
  int   cur_idx = 0;

  control_sequencer #(.IR_W(32), .OPC_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON_out(CON_out),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .IncPC(IncPC), .Read(Read), .Write(Write), .GRA(GRA),
    .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .CON_in(CON_in), .operation(operation), .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  function automatic obs_t sample();
    obs_t got;
    got = {PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, CON_in,
           operation, Run, Illegal};
    return got;
  endfunction

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e;
      obs_t got;
      e   = q.pop_front();
      got = sample();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL strobes t%0d.c%0d got=%h exp=%h", e.tag, e.idx, got, e.v);
      end
    end
  end

  task automatic check_zero_now(input int where);
    obs_t got;
    got = sample();
    total++;
    if (got !== ZERO) begin
      bad++;
      $display("FAIL reset state at %0d: outputs=%h not all zero", where, got);
    end
  endtask

  task automatic drain_or_fail(input int unsigned limit);
    int unsigned k;
    k = 0;
    while (q.size() > 0 && k < limit) begin
      @(posedge Clock); #1;
      k++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL wait expired: %0d expectations still pending", q.size());
    end
  endtask

  task automatic cyc(input obs_t v);
    exp_t e;
    e.v = v; e.tag = cur_tag; e.idx = cur_idx;
    q.push_back(e);
    cur_idx++;
    @(posedge Clock); #1;
  endtask

  function automatic obs_t busy();
    obs_t o = '0;
    o.Run = 1'b1;
    return o;
  endfunction

  // Expected strobe sets for one instruction, fetch through last execute step.
  task automatic model_instr(input logic [31:0] ir, input logic con);
    obs_t o;
    int   op;
    int   alu;
    op = int'(ir[31:27]);
    seq.delete();
    o = busy(); o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.PCin = 1; seq.push_back(o);
    o = busy(); o.Read = 1; o.MDRin = 1; seq.push_back(o);
    o = busy(); o.MDRout = 1; o.IRin = 1; seq.push_back(o);
    if (op inside {[3:14]}) begin
      alu = (op <= 11) ? op : (op == 12) ? 3 : (op == 13) ? 5 : 6;
      o = busy(); o.GRB = 1; o.Rout = 1; o.Yin = 1; seq.push_back(o);
      o = busy(); o.Zin = 1; o.operation = 5'(alu);
      if (op <= 11) begin o.GRC = 1; o.Rout = 1; end else o.Cout = 1;
      seq.push_back(o);
      o = busy(); o.Zlowout = 1; o.GRA = 1; o.Rin = 1; seq.push_back(o);
    end else if (op == 19) begin
      o = busy(); o.GRA = 1; o.Rout = 1; o.CON_in = 1; seq.push_back(o);
      o = busy(); o.PCout = 1; o.Yin = 1; seq.push_back(o);
      o = busy(); o.Cout = 1; o.Zin = 1; o.operation = 5'd3; seq.push_back(o);
      if (con) begin
        o = busy(); o.Zlowout = 1; o.PCin = 1; seq.push_back(o);
      end
    end else if (op == 20) begin
      o = busy(); o.GRA = 1; o.Rout = 1; o.PCin = 1; seq.push_back(o);
    end else if (op == 26 || op == 27) begin
      seq.push_back(busy());
    end else begin
      o = busy(); o.Illegal = 1; seq.push_back(o);
    end
  endtask

  // stop_mode: 0 never, 1 raised from T4 onward, 2 random each cycle.
  task automatic run_instr(input logic [31:0] ir, input logic con,
                           input int stop_mode, input int abort_at);
    int unsigned n;
    cur_tag++;
    cur_idx = 0;
    model_instr(ir, con);
    n = seq.size();
    for (int unsigned i = 0; i < n; i++) begin
      IR = ir;
      CON_out = con;
      case (stop_mode)
        1:       Stop = (i >= 4);
        2:       Stop = ($urandom_range(0, 3) == 0);
        default: Stop = 1'b0;
      endcase
      if (int'(i) == abort_at) begin
        Stop = 1'b0;
        Reset = 1'b1;
        #1;
        check_zero_now(cur_tag);
        cyc(ZERO);
        cyc(ZERO);
        Reset = 1'b0;
        cyc(ZERO);
        return;
      end
      cyc(seq[i]);
    end
    if (ir[31:27] != 5'b11011 && Stop) begin
      int unsigned k;
      k = 0;
      do begin
        Stop = (k >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
        k++;
        cyc(ZERO);
      end while (Stop && k < 8);
      total++;
      if (Stop) begin
        bad++;
        $display("FAIL wait expired: idle wait t%0d never released", cur_tag);
        Stop = 1'b0;
      end
      drain_or_fail(4);
    end
  endtask

  initial begin
    int legal[15] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 19, 20, 26};
    @(posedge Clock); #1;
    check_zero_now(0);
    cyc(ZERO);
    cyc(ZERO);
    Reset = 1'b0;
    cyc(ZERO);

    run_instr(32'h18918000, 1'b0, 0, 2);
    run_instr(32'h18918000, 1'b0, 0, -1);
    run_instr(32'h99000023, 1'b1, 0, -1);
    run_instr(32'h99000023, 1'b0, 0, -1);
    run_instr(32'h60900005, 1'b0, 1, -1);
    run_instr(32'hF8000000, 1'b0, 0, -1);
    run_instr(32'h18918000, 1'b0, 0, -1);

    for (int unsigned n = 0; n < 150; n++) begin
      int op;
      if ($urandom_range(0, 5) == 0) begin
        do op = int'($urandom_range(0, 31)); while (op == 27);
      end else begin
        op = legal[$urandom_range(0, 14)];
      end
      run_instr({5'(op), 27'($urandom)}, 1'($urandom_range(0, 1)), 2, -1);
    end

    run_instr(32'hD8000000, 1'b0, 0, -1);
    for (int unsigned n = 0; n < 10; n++) begin
      Stop = 1'($urandom_range(0, 1));
      IR = $urandom;
      CON_out = 1'($urandom_range(0, 1));
      cyc(ZERO);
    end
    Stop = 1'b0;
    Reset = 1'b1;
    #1;
    check_zero_now(-1);
    cyc(ZERO);
    Reset = 1'b0;
    cyc(ZERO);
    run_instr(32'hA0000000, 1'b0, 0, -1);
    drain_or_fail(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore-style control unit that replaces bench-driven control of the 32-bit CPU datapath.
- Decodes IR and issues every datapath strobe each cycle: fetch, R-type ALU, immediate ALU, conditional branch, jr, nop, halt.
- Sits beside the datapath: consumes the IR contents and CON_out, drives the PC/MAR/MDR/IR/Y/Z enables, the select-and-encode controls (GRA/GRB/GRC/Rin/Rout/BAout) and the ALU operation code.

Parameters:
- IR_W, 32, instruction register width.
- OPC_W, 5, opcode width; opcode is IR[31:27].

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stop  in  1  level request to pause at the next instruction boundary.
- IR  in  IR_W  current instruction register contents.
- CON_out  in  1  registered branch-condition result from the datapath.
- PCout, Zlowout, MDRout, Cout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables.
- IncPC, Read, Write  out  1 each  PC increment, memory read, memory write.
- GRA, GRB, GRC, Rin, Rout, BAout, CON_in  out  1 each  select/encode and CON load controls.
- operation  out  5  ALU operation code.
- Run  out  1  high while executing; low in reset, idle and halt.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset asserted: state=RST, all outputs 0, including Run and Illegal, asynchronously.
- RST to F0 on the first edge after release.
- Outputs are a pure function of state. The IR opcode is used only in F2/T3 decode paths.
- Exactly one state per clock.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, br 10011, jr 10100, nop 11010, halt 11011.
- States and outputs:
  - F0: PCout, MARin, IncPC, PCin.
  - F1: Read, MDRin.
  - F2: MDRout, IRin.
  - T3 (IR valid):
    - R-type and I-type: GRB, Rout, Yin.
    - br: GRA, Rout, CON_in.
    - jr: GRA, Rout, PCin.
    - nop: no strobes.
  - T4:
    - R-type: GRC, Rout, Zin, operation=opcode.
    - I-type: Cout, Zin, operation=00011/00101/00110 for addi/andi/ori.
    - br: PCout, Yin.
  - T5:
    - R/I-type: Zlowout, GRA, Rin.
    - br: Cout, Zin, operation=00011.
  - T6 (br only): Zlowout, PCin.
- Transitions:
  - F0 to F1 to F2 to T3.
  - T3: jr and nop go to END. halt goes to HALT. Unsupported opcodes go to END and pulse Illegal during T3. All other opcodes go to T4.
  - T4 to T5.
  - T5: R/I-type go to END. br goes to T6 if CON_out=1, else END; CON_out is stable from T4.
  - T6 to END.
- END is a virtual boundary, not a state. Go to IDLE if Stop=1, else F0.
- IDLE: all strobes 0, Run=0. Go to F0 on the first edge with Stop=0.
- HALT: all strobes 0, Run=0. Sticky; only Reset exits.
- Cycle counts: R/I-type 6, br not-taken 6, br taken 7, jr and nop 4.
- operation is 00000 in every state not listed above.
- Write is never asserted; it is reserved for ld/st, which are out of scope.
- Reset mid-instruction aborts immediately. No partial register writes, because every state's strobes drop asynchronously.
- Stop is ignored mid-instruction; it is sampled only at END.

Decomposition:
- cpu_ctrl_pkg holds:
  - opcode localparams as listed;
  - the state enum RST, F0, F1, F2, T3, T4, T5, T6, IDLE, HALT;
  - instruction class codes RTYPE, ITYPE, BR, JR, NOP, HALT, BAD.
- One sub-module, instr_class_decode: combinational opcode to class plus ALU operation mapping, instantiated once.

Test Plan:
- Reset at cycle 3 of an add, release after 2 cycles -> all outputs 0 during reset. F0 strobes (PCout, MARin, IncPC, PCin) on the first cycle after release. Run=1.
- IR=32'h18918000 (add R1,R2,R3) -> exactly 6 cycles F0..T5:
  - T3: GRB, Rout, Yin.
  - T4: GRC, Rout, Zin, operation=00011.
  - T5: Zlowout, GRA, Rin.
  - Then F0.
- IR=32'h99000023 (brzr R2,35), CON_out=1 from T4 -> T3 asserts GRA, Rout, CON_in; T5 asserts Cout, Zin, operation=00011; T6 asserts Zlowout, PCin; 7 cycles total.
- Same IR with CON_out=0 -> T5 followed directly by F0. PCin never high after F0; 6 cycles.
- IR=32'hD8000000 (halt), then Stop toggling and new IR values -> HALT held, Run=0, all strobes 0 until Reset.
- Stop=1 raised during T4 of addi (IR=32'h60900005) -> instruction completes with operation=00011 in T4. Then IDLE with Run=0. F0 on the edge after Stop=0. IR opcode 11111 -> Illegal pulse for 1 cycle, then F0.
